// File: rtl/sound_scheduler.sv
// Fixed-priority speaker arbiter (alarm > chime > beep) with ms-tick sound timing.
// Optional snooze support is built when SOUND_SNOOZE_EN is defined.
module sound_scheduler #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned BEEP_MS   = 50,
    parameter int unsigned PIP_MS    = 200,
    parameter int unsigned GAP_MS    = 300,
    parameter int unsigned ALARM_MS  = 180000,
    parameter int unsigned SNOOZE_MS = 300000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarm_req,
    input  logic       alarm_stop,
    input  logic       snooze,
    input  logic       chime_req,
    input  logic [3:0] chime_count,
    input  logic       beep_req,
    output logic       tone_en,
    output logic [1:0] tone_sel,
    output logic [2:0] grant,
    output logic       busy
);
    localparam int unsigned TW = 20;
    localparam int unsigned PW = $clog2(TICK_DIV + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_BEEP, S_PIP_ON, S_PIP_GAP, S_ALARM, S_SNOOZE
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] pre;
    logic [TW-1:0] ms;
    logic [TW-1:0] dur_c;
    logic [3:0]    pips, pips_n;
    logic [3:0]    pend, pend_n;
    logic          done_c, alarm_go_c, chime_ok_c;
    logic          tone_en_c, busy_c;
    logic [1:0]    tone_sel_c;
    logic [2:0]    grant_c;

`ifndef SOUND_SNOOZE_EN
    logic snooze_unused;
    assign snooze_unused = snooze;
`endif

    // Length of the current phase in ms
    always_comb begin
        dur_c = '0;
        case (state)
            S_BEEP:    dur_c = TW'(BEEP_MS);
            S_PIP_ON:  dur_c = TW'(PIP_MS);
            S_PIP_GAP: dur_c = TW'(GAP_MS);
            S_ALARM:   dur_c = TW'(ALARM_MS);
            S_SNOOZE:  dur_c = TW'(SNOOZE_MS);
            default:   dur_c = '0;
        endcase
    end

    assign done_c     = (pre == PW'(TICK_DIV - 1)) && (ms == dur_c - TW'(1));
    assign alarm_go_c = alarm_req & ~alarm_stop;
    assign chime_ok_c = chime_req && (chime_count != 4'd0);

    // Next-state, pip/pending bookkeeping and next output values
    always_comb begin
        state_n = state;
        pips_n  = pips;
        pend_n  = pend;
        case (state)
            S_IDLE: begin
                if (alarm_go_c) begin
                    state_n = S_ALARM;
                    if (chime_ok_c) pend_n = chime_count;
                end else if (chime_ok_c) begin
                    state_n = S_PIP_ON;
                    pips_n  = chime_count;
                    pend_n  = 4'd0;
                end else if (pend != 4'd0) begin
                    state_n = S_PIP_ON;
                    pips_n  = pend;
                    pend_n  = 4'd0;
                end else if (beep_req) begin
                    state_n = S_BEEP;
                end
            end
            S_BEEP: begin
                if (chime_ok_c) pend_n = chime_count;
                if (alarm_go_c)  state_n = S_ALARM;
                else if (done_c) state_n = S_IDLE;
            end
            S_PIP_ON: begin
                if (alarm_go_c) begin
                    state_n = S_ALARM;
                end else if (done_c) begin
                    pips_n  = pips - 4'd1;
                    state_n = (pips > 4'd1) ? S_PIP_GAP : S_IDLE;
                end
            end
            S_PIP_GAP: begin
                if (alarm_go_c)  state_n = S_ALARM;
                else if (done_c) state_n = S_PIP_ON;
            end
            S_ALARM: begin
                if (chime_ok_c) pend_n = chime_count;
                if (alarm_stop || done_c) state_n = S_IDLE;
`ifdef SOUND_SNOOZE_EN
                else if (snooze) state_n = S_SNOOZE;
`endif
            end
`ifdef SOUND_SNOOZE_EN
            S_SNOOZE: begin
                if (chime_ok_c) pend_n = chime_count;
                if (alarm_stop)  state_n = S_IDLE;
                else if (done_c) state_n = S_ALARM;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so outputs register alongside it
    always_comb begin
        tone_en_c  = 1'b0;
        tone_sel_c = 2'd0;
        grant_c    = 3'b000;
        busy_c     = (state_n != S_IDLE);
        case (state_n)
            S_BEEP:    begin tone_en_c = 1'b1; tone_sel_c = 2'd1; grant_c = 3'b001; end
            S_PIP_ON:  begin tone_en_c = 1'b1; tone_sel_c = 2'd2; grant_c = 3'b010; end
            S_PIP_GAP: begin                   tone_sel_c = 2'd2; grant_c = 3'b010; end
            S_ALARM:   begin tone_en_c = 1'b1; tone_sel_c = 2'd3; grant_c = 3'b100; end
            S_SNOOZE:  begin                                      grant_c = 3'b100; end
            default:   begin end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pips     <= 4'd0;
            pend     <= 4'd0;
            pre      <= '0;
            ms       <= '0;
            tone_en  <= 1'b0;
            tone_sel <= 2'd0;
            grant    <= 3'b000;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            pips     <= pips_n;
            pend     <= pend_n;
            tone_en  <= tone_en_c;
            tone_sel <= tone_sel_c;
            grant    <= grant_c;
            busy     <= busy_c;
            // Timebase restarts on every state entry
            if (state_n != state) begin
                pre <= '0;
                ms  <= '0;
            end else if (pre == PW'(TICK_DIV - 1)) begin
                pre <= '0;
                ms  <= ms + TW'(1);
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end
endmodule
